regfile_clr: RTL
================

Name: regfile_clr

Overview:
- Parametrised successor to the 16x8 two-read/one-write register bank used by the datapath.
- Generalised in width and depth, with an optional hardwired-zero register 0.
- Adds a sequenced clear engine: wipes every entry one per clock after reset or on request, with busy and write-reject status.
- Sits between the controller and the ALU/output muxes; the controller must hold off on busy.

Parameters:
- WIDTH, 8: data width of each register.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: 1 means entry 0 always reads 0 and writes to it are discarded; 0 means entry 0 is an ordinary register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- we3  in  1  write enable.
- wa3  in  ADDR_W  write address.
- wd3  in  WIDTH  write data.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- clr  in  1  clear request, sampled only in IDLE.
- rd1  out  WIDTH  read data, port 1 (combinational).
- rd2  out  WIDTH  read data, port 2 (combinational).
- busy  out  1  clear sweep in progress.
- wr_rej  out  1  registered one-cycle pulse: a write was dropped.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Storage: DEPTH x WIDTH array with no per-entry reset, so it stays RAM-inferable.
- State machine, two states: IDLE and CLEAR. Clear pointer cnt is ADDR_W bits.
- Reset (sampled high at an edge):
  - state <= CLEAR, cnt <= 0, wr_rej <= 0.
  - busy is 1 from the cycle after that edge.
  - Reset mid-sweep restarts the sweep at cnt = 0.
- CLEAR state, each edge:
  - mem[cnt] <= 0, cnt <= cnt+1.
  - When cnt == DEPTH-1: state <= IDLE and cnt wraps to 0.
  - The sweep lasts exactly DEPTH cycles; busy = (state == CLEAR).
- IDLE with clr = 1 at an edge: state <= CLEAR, cnt <= 0.
- clr while in CLEAR is ignored; it neither restarts nor extends the sweep.
- Writes, in IDLE:
  - If we3 = 1 and clr = 0: mem[wa3] <= wd3 at the edge.
  - The new data is visible on rd1/rd2 from the next cycle (1-cycle write-to-read latency).
  - If ZERO_REG = 1 and wa3 = 0: the write is discarded silently (wr_rej stays 0).
- Write rejection:
  - If we3 = 1 while busy = 1, or in IDLE together with clr = 1 (clr has priority): write dropped, wr_rej <= 1 for one cycle.
  - Otherwise wr_rej <= 0.
- Reads:
  - Combinational.
  - rd = 0 when busy = 1.
  - rd = 0 when ZERO_REG = 1 and the read address is 0.
  - Otherwise rd = mem[addr].
  - Both ports may read the same address.
- Back-to-back writes to the same address on consecutive cycles: last one wins.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE with we3 = 1, clr = 0, and ra == wa3 (and not the zero register), rd returns wd3 in the same cycle (write-first forwarding). This applies per port independently.
- Not defined: a read of the address being written returns the old content until the edge.
- busy and the zero-register rules override the bypass in both cases.

Test Plan (WIDTH=8, ADDR_W=4, ZERO_REG=1):
- Reset for 1 cycle, then release -> busy = 1 for exactly 16 cycles, then 0. Reads of ra1 = 5 and ra2 = 15 give 0 throughout and after.
- IDLE: write 0xA5 to reg 3, then read ra1 = 3 and ra2 = 3 on the next cycle -> rd1 = rd2 = 0xA5. Write 0x7E to reg 0 -> rd = 0 and wr_rej = 0.
- Write 0x11 to reg 4, assert clr for 1 cycle, and hold we3 = 1 (wa3 = 6, wd3 = 0x22) during the next 3 cycles -> wr_rej = 1 in each of those cycles. After the 16-cycle sweep, reg 4 = 0x00 and reg 6 = 0x00.
- Assert reset at sweep cycle 9 -> the sweep restarts at cnt = 0 and busy stays high for 16 more cycles. A second clr mid-sweep does not lengthen busy.
- Same cycle: we3 = 1, wa3 = 8, wd3 = 0x3C, ra1 = 8 -> rd1 = 0x3C with REGFILE_BYPASS_EN defined, old value (0x00) without it. Next cycle rd1 = 0x3C in both builds.
- ZERO_REG = 0 build: write 0x99 to reg 0 -> rd1 = 0x99 on the next cycle, and 0 again after a clr sweep.

Source files
------------

// File: rtl/regfile_clr.sv
// regfile_clr: parametrised two-read/one-write register file with a sequenced clear engine.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_clr #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              clr,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy,
  output logic              wr_rej
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_rej_q, wr_rej_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [WIDTH-1:0]    mem_wd;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Single write port shared by the clear sweep and normal writes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_rej_d = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = wa3;
    mem_wd   = wd3;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d  = CLEAR;
          cnt_d    = '0;
          wr_rej_d = we3;
        end else if (we3) begin
          mem_we = !is_zero_reg(wa3);
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_wa   = cnt_q;
        mem_wd   = '0;
        cnt_d    = cnt_q + 1'b1;
        wr_rej_d = we3;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      wr_rej_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_rej_q <= wr_rej_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the clear sweep wipes it instead.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign busy   = (state_q == CLEAR);
  assign wr_rej = wr_rej_q;

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = (state_q == IDLE) && we3 && !clr;
`endif

  // Busy and the zero register take precedence over any forwarded data.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [WIDTH-1:0] r;
    r = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (ra == wa3)) r = wd3;
`endif
    if (busy || is_zero_reg(ra)) r = '0;
    return r;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule
